// File: rtl/maj_eval_pkg.sv
// Shared types and signal-index constants for the majority-inverter network evaluator.
package maj_eval_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    DONE
  } state_t;

  // Selector fields are stored wider than any practical IDX_W so the entry type need not be parameterized
  localparam int SEL_MAX_W = 8;

  typedef struct packed {
    logic [SEL_MAX_W-1:0] sel_a;
    logic [SEL_MAX_W-1:0] sel_b;
    logic [SEL_MAX_W-1:0] sel_c;
    logic [2:0]           inv;
  } node_entry_t;

  localparam int CONST0  = 0;
  localparam int IN_BASE = CONST0 + 1;

  function automatic int node_base(input int n_in);
    return IN_BASE + n_in;
  endfunction

endpackage

// File: rtl/maj3_cell.sv
// Combinational 3-input majority with independent complement on each input.
module maj3_cell (
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic [2:0] inv,
  output logic       y
);

  logic aa, bb, cc;

  assign aa = a ^ inv[0];
  assign bb = b ^ inv[1];
  assign cc = c ^ inv[2];
  assign y  = (aa & bb) | (aa & cc) | (bb & cc);

endmodule

// File: rtl/maj_net_eval.sv
// Sequential evaluator for a programmable MAJ3 network, one node per clock.
// Optional build macro MAJ_TRACE_EN exposes the registered node values on node_vec.
module maj_net_eval
  import maj_eval_pkg::*;
#(
  parameter int N_IN    = 7,
  parameter int N_NODES = 8,
  parameter int SIG_W   = 1 + N_IN + N_NODES,
  parameter int IDX_W   = $clog2(SIG_W),
  parameter int AW      = $clog2(N_NODES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [3*IDX_W-1:0] prog_sel,
  input  logic [2:0]         prog_inv,
  output logic               prog_ready,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_IN-1:0]    x,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out,
  output logic               out_err
`ifdef MAJ_TRACE_EN
  ,
  output logic [N_NODES-1:0] node_vec
`endif
);

  localparam int NODE_BASE = node_base(N_IN);

  state_t            state, state_nx;
  logic [AW-1:0]     k;
  node_entry_t       prog [N_NODES+1];
  logic [N_IN-1:0]   x_q;
  logic [N_NODES-1:0] node_q;
  logic              err_q;
  logic              out_q;
  logic              out_err_q;

  logic [SIG_W-1:0]  sig;
  node_entry_t       entry;
  node_entry_t       wr_entry;
  logic [1:0]        op_a, op_b, op_c;
  logic              node_y;
  logic              wr_ok;

  // A selector is legal only if it names the constant, an input, or an already computed node
  function automatic logic [1:0] rd_op(input logic [SIG_W-1:0] s,
                                       input logic [SEL_MAX_W-1:0] sel,
                                       input int lim);
    logic [SIG_W-1:0] sh;
    sh = s >> sel;
    if (int'(sel) < NODE_BASE + lim) return {1'b0, sh[0]};
    return 2'b10;
  endfunction

  assign prog_ready = (state == IDLE);
  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign out        = out_q;
  assign out_err    = out_err_q;

`ifdef MAJ_TRACE_EN
  assign node_vec = node_q;
`endif

  assign sig   = {node_q, x_q, 1'b0};
  assign entry = prog[k];
  assign op_a  = rd_op(sig, entry.sel_a, int'(k));
  assign op_b  = rd_op(sig, entry.sel_b, int'(k));
  assign op_c  = rd_op(sig, entry.sel_c, int'(k));

  assign wr_entry.sel_a = SEL_MAX_W'(prog_sel[IDX_W-1:0]);
  assign wr_entry.sel_b = SEL_MAX_W'(prog_sel[2*IDX_W-1:IDX_W]);
  assign wr_entry.sel_c = SEL_MAX_W'(prog_sel[3*IDX_W-1:2*IDX_W]);
  assign wr_entry.inv   = prog_inv;
  assign wr_ok          = prog_we && (state == IDLE) && (int'(prog_addr) <= N_NODES);

  maj3_cell u_cell (
    .a   (op_a[0]),
    .b   (op_b[0]),
    .c   (op_c[0]),
    .inv (entry.inv),
    .y   (node_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = EVAL;
      EVAL:    if (int'(k) == N_NODES) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // k == N_NODES is the extra step that resolves the output selector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k         <= '0;
      x_q       <= '0;
      node_q    <= '0;
      err_q     <= 1'b0;
      out_q     <= 1'b0;
      out_err_q <= 1'b0;
      for (int i = 0; i <= N_NODES; i++) prog[i] <= '0;
    end else begin
      if (wr_ok) prog[prog_addr] <= wr_entry;
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_q    <= x;
            node_q <= '0;
            err_q  <= 1'b0;
            k      <= '0;
          end
        end
        EVAL: begin
          if (int'(k) < N_NODES) begin
            for (int i = 0; i < N_NODES; i++)
              if (k == AW'(i)) node_q[i] <= node_y;
            err_q <= err_q | op_a[1] | op_b[1] | op_c[1];
            k     <= k + 1'b1;
          end else begin
            out_q     <= op_a[0] ^ entry.inv[0];
            out_err_q <= err_q | op_a[1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maj_net_eval.sv
// Directed self-checking bench for maj_net_eval with hand-computed expectations.
module tb_maj_net_eval;

  localparam int N_IN    = 7;
  localparam int N_NODES = 8;
  localparam int IDX_W   = 4;
  localparam int AW      = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               prog_we = 1'b0;
  logic [AW-1:0]      prog_addr = '0;
  logic [3*IDX_W-1:0] prog_sel = '0;
  logic [2:0]         prog_inv = '0;
  logic               prog_ready;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [N_IN-1:0]    x = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic               out;
  logic               out_err;
`ifdef MAJ_TRACE_EN
  logic [N_NODES-1:0] node_vec;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  maj_net_eval dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_sel   (prog_sel),
    .prog_inv   (prog_inv),
    .prog_ready (prog_ready),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x          (x),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .out_err    (out_err)
`ifdef MAJ_TRACE_EN
    ,
    .node_vec   (node_vec)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic gold(input logic [6:0] v);
    logic n0, n1, n2, n3, n4;
    n0 = maj(v[0], v[1], v[2]);
    n1 = maj(v[4], v[5], v[6]);
    n2 = maj(v[0], v[5], n0);
    n3 = maj(v[1], v[2], v[4]);
    n4 = maj(n1, n2, n3);
    return maj(v[3], n0, n4);
  endfunction

  // All tasks start and end 1 time unit after a rising edge
  task automatic wr(input int addr, input int sa, input int sb, input int sc, input logic [2:0] inv);
    prog_we   = 1'b1;
    prog_addr = AW'(addr);
    prog_sel  = {IDX_W'(sc), IDX_W'(sb), IDX_W'(sa)};
    prog_inv  = inv;
    @(posedge clk); #1;
    prog_we   = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) chk("timeout", 0, 1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run(input logic [6:0] xv, output logic o, output logic e, output int lat);
    in_valid = 1'b1;
    x        = xv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    o = out;
    e = out_err;
    consume();
  endtask

  initial begin
    logic o, e;
    int   lat;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_prog_ready", prog_ready, 1);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_out_err", out_err, 0);

    run(7'h7F, o, e, lat);
    chk("default_out", o, 0);
    chk("default_err", e, 0);
    chk("default_latency", lat, 9);

    // node0 = MAJ(x0,x1,x2), out = node0
    wr(0, 1, 2, 3, 3'b000);
    wr(8, 8, 0, 0, 3'b000);
    run(7'b0000011, o, e, lat);
    chk("single_011", o, 1);
    chk("single_latency", lat, 9);
    run(7'b0000001, o, e, lat);
    chk("single_001", o, 0);
    chk("single_err", e, 0);

    wr(0, 1, 2, 3, 3'b000);
    wr(1, 5, 6, 7, 3'b000);
    wr(2, 1, 6, 8, 3'b000);
    wr(3, 2, 3, 5, 3'b000);
    wr(4, 9, 10, 11, 3'b000);
    wr(5, 4, 8, 12, 3'b000);
    wr(8, 13, 0, 0, 3'b000);
    for (int i = 0; i < 128; i++) begin
      run(7'(i), o, e, lat);
      chk($sformatf("nested_x%0d", i), o, gold(7'(i)));
      chk($sformatf("nested_err_x%0d", i), e, 0);
    end

    // node0 = MAJ(~x0,x1,0), out = ~node0
    wr(0, 1, 2, 0, 3'b001);
    wr(8, 8, 0, 0, 3'b001);
    run(7'b0000000, o, e, lat);
    chk("compl_x0", o, 1);
    run(7'b0000010, o, e, lat);
    chk("compl_x2", o, 0);
    chk("compl_err", e, 0);

    // forward reference: node0 operand a = node3
    wr(0, 11, 2, 3, 3'b000);
    wr(8, 8, 0, 0, 3'b000);
    run(7'b0000110, o, e, lat);
    chk("fwd_out_110", o, 1);
    chk("fwd_err_110", e, 1);
    run(7'b0000010, o, e, lat);
    chk("fwd_out_010", o, 0);
    chk("fwd_err_010", e, 1);
    wr(0, 1, 2, 3, 3'b000);
    run(7'b0000110, o, e, lat);
    chk("clean_out", o, 1);
    chk("clean_err", e, 0);

    // out_ready stall
    in_valid = 1'b1;
    x = 7'b0000011;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_out", out, 1);
      chk("stall_in_ready", in_ready, 0);
    end
    consume();
    chk("after_consume_valid", out_valid, 0);

    // write attempted during EVAL must be dropped
    in_valid = 1'b1;
    x = 7'b0000011;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("eval_prog_ready", prog_ready, 0);
    prog_we   = 1'b1;
    prog_addr = '0;
    prog_sel  = '0;
    prog_inv  = 3'b000;
    @(posedge clk); #1;
    prog_we   = 1'b0;
    wait_out(lat);
    chk("evalwr_out", out, 1);
    consume();
    run(7'b0000011, o, e, lat);
    chk("evalwr_rerun", o, 1);

    // reset mid-EVAL
    in_valid = 1'b1;
    x = 7'h7F;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ready", prog_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_valid", out_valid, 0);
    run(7'h7F, o, e, lat);
    chk("postrst_out", o, 0);
    chk("postrst_err", e, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
